// File: rtl/avalon_mm_pkg.sv
// Shared types and constants for the two-master Avalon-MM arbiter.
package avalon_mm_pkg;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } grant_id_t;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } arb_state_t;

    localparam logic BURSTCOUNT = 1'b1;

    function automatic grant_id_t other_master(input grant_id_t id);
        return (id == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/pend_id_fifo.sv
// Small synchronous FIFO holding the issuing master of each outstanding read.
// A push is allowed while full as long as a pop happens in the same cycle.
module pend_id_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count/pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Round-robin arbiter sharing one MM bridge slave port between the instruction
// and data masters, with pipelined read-return steering.
module avalon_mm_arbiter
    import avalon_mm_pkg::*;
#(
    parameter int unsigned ADDR_W   = 28,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_PEND = 4
) (
    input  logic                clk_clk,
    input  logic                reset_reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   br_address,
    output logic                br_read,
    output logic                br_write,
    output logic [DATA_W-1:0]   br_writedata,
    output logic [DATA_W/8-1:0] br_byteenable,
    output logic                br_burstcount,
    output logic                br_debugaccess,
    input  logic                br_waitrequest,
    input  logic [DATA_W-1:0]   br_readdata,
    input  logic                br_readdatavalid
);

    arb_state_t state_q, state_d;
    grant_id_t  last_grant_q, last_grant_d;
    grant_id_t  owner_q, owner_d;
    grant_id_t  sel;
    grant_id_t  head_id;

    logic       m0_req, m1_req;
    logic       sel_req, sel_rd, sel_wr;
    logic       read_blocked, accept;
    logic       fifo_full, fifo_empty;
    logic [0:0] fifo_head, push_id;
    logic       rdv_hit;

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;

    // HOLD pins the owner; in IDLE a tie goes to whoever did not win last.
    always_comb begin
        sel = M0;
        if (state_q == StHold) begin
            sel = owner_q;
        end else if (m0_req && m1_req) begin
            sel = other_master(last_grant_q);
        end else if (m1_req) begin
            sel = M1;
        end
    end

    assign sel_rd  = (sel == M1) ? m1_read  : m0_read;
    assign sel_wr  = (sel == M1) ? m1_write : m0_write;
    assign sel_req = sel_rd | sel_wr;

    assign br_address    = (sel == M1) ? m1_address    : m0_address;
    assign br_writedata  = (sel == M1) ? m1_writedata  : m0_writedata;
    assign br_byteenable = (sel == M1) ? m1_byteenable : m0_byteenable;

    // A return beat this cycle frees a slot, so a read may issue into a full FIFO.
    assign read_blocked = sel_rd & fifo_full & ~br_readdatavalid;

    assign br_read  = ~reset_reset & sel_rd & ~read_blocked;
    assign br_write = ~reset_reset & sel_wr & ~sel_rd;
    assign accept   = ~reset_reset & sel_req & ~br_waitrequest & ~read_blocked;

    assign m0_waitrequest = ~(accept & (sel == M0));
    assign m1_waitrequest = ~(accept & (sel == M1));

    assign br_burstcount  = BURSTCOUNT;
    assign br_debugaccess = 1'b0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    last_grant_d = sel;
                end else if (sel_req && !read_blocked) begin
                    state_d = StHold;
                    owner_d = sel;
                end
            end
            StHold: begin
                if (!sel_req) begin
                    state_d = StIdle;
                end else if (accept) begin
                    last_grant_d = sel;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q      <= StIdle;
            last_grant_q <= M1;
            owner_q      <= M0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
        end
    end

    assign push_id = sel;

    pend_id_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_PEND)
    ) u_pend_id_fifo (
        .clk       (clk_clk),
        .rst       (reset_reset),
        .push      (accept & sel_rd),
        .push_data (push_id),
        .pop       (br_readdatavalid),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_id = grant_id_t'(fifo_head);
    assign rdv_hit = ~reset_reset & br_readdatavalid & ~fifo_empty;

    assign m0_readdatavalid = rdv_hit & (head_id == M0);
    assign m1_readdatavalid = rdv_hit & (head_id == M1);
    assign m0_readdata      = br_readdata;
    assign m1_readdata      = br_readdata;

    // Protocol violations by neighbours: beats with nothing pending, owner leaving HOLD.
    rdv_needs_pending: assert property (@(posedge clk_clk) disable iff (reset_reset)
        br_readdatavalid |-> !fifo_empty);

    owner_keeps_request: assert property (@(posedge clk_clk) disable iff (reset_reset)
        (state_q == StHold) |-> sel_req);

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Scoreboard bench for avalon_mm_arbiter: directed scenarios plus randomized
// two-master traffic checked against a queue-based arbitration model.
module tb_avalon_mm_arbiter;

    localparam int ADDR_W   = 28;
    localparam int DATA_W   = 32;
    localparam int MAX_PEND = 4;
    localparam int N_RAND   = 60;

    typedef struct packed {
        logic [1:0]        id;
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        be;
    } cmd_t;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic [ADDR_W-1:0] m0_address, m1_address, br_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata, br_writedata;
    logic [3:0]        m0_byteenable, m1_byteenable, br_byteenable;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata, br_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic              br_read, br_write, br_burstcount, br_debugaccess;
    logic              br_waitrequest, br_readdatavalid;

    int checks = 0;
    int errors = 0;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_rd0[$];
    logic [31:0] exp_rd1[$];

    bit model_on     = 0;
    bit masters_done = 0;
    int m_last;
    bit m_locked;
    int m_owner;
    int m_pend[$];

    avalon_mm_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_PEND (MAX_PEND)
    ) dut (
        .clk_clk          (clk_clk),
        .reset_reset      (reset_reset),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .br_address       (br_address),
        .br_read          (br_read),
        .br_write         (br_write),
        .br_writedata     (br_writedata),
        .br_byteenable    (br_byteenable),
        .br_burstcount    (br_burstcount),
        .br_debugaccess   (br_debugaccess),
        .br_waitrequest   (br_waitrequest),
        .br_readdata      (br_readdata),
        .br_readdatavalid (br_readdatavalid)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    task automatic cyc();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_clk);
    endtask

    task automatic push_cmd(input int id, input logic [ADDR_W-1:0] a, input logic wr,
                            input logic [DATA_W-1:0] d, input logic [3:0] be);
        cmd_t c;
        c.id = 2'(id); c.addr = a; c.wr = wr; c.wdata = d; c.be = be;
        exp_cmd.push_back(c);
    endtask

    task automatic clear_inputs();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        br_waitrequest = 0; br_readdatavalid = 0; br_readdata = '0;
    endtask

    task automatic do_reset();
        cyc();
        reset_reset = 1;
        clear_inputs();
        repeat (2) cyc();
        reset_reset = 0;
    endtask

    // Monitor: every accepted bridge command and every return beat consumes one expectation.
    always @(negedge clk_clk) begin
        if (!reset_reset) begin
            if ((br_read || br_write) && !br_waitrequest) begin
                int act_id;
                cmd_t e;
                act_id = !m0_waitrequest ? (!m1_waitrequest ? 2 : 0)
                                         : (!m1_waitrequest ? 1 : 3);
                if (exp_cmd.size() == 0) begin
                    flag("unexpected_cmd", 64'(br_address));
                end else begin
                    e = exp_cmd.pop_front();
                    check("cmd_master", 64'(act_id), 64'(e.id));
                    check("cmd_addr", 64'(br_address), 64'(e.addr));
                    check("cmd_is_write", 64'(br_write), 64'(e.wr));
                    if (e.wr) check("cmd_wdata", 64'(br_writedata), 64'(e.wdata));
                    check("cmd_be", 64'(br_byteenable), 64'(e.be));
                end
            end
            if (m0_readdatavalid) begin
                if (exp_rd0.size() == 0) flag("unexpected_m0_rdv", 64'(m0_readdata));
                else check("m0_readdata", 64'(m0_readdata), 64'(exp_rd0.pop_front()));
            end
            if (m1_readdatavalid) begin
                if (exp_rd1.size() == 0) flag("unexpected_m1_rdv", 64'(m1_readdata));
                else check("m1_readdata", 64'(m1_readdata), 64'(exp_rd1.pop_front()));
            end
            if (br_readdatavalid && !m0_readdatavalid && !m1_readdatavalid)
                flag("beat_dropped", 64'(br_readdata));
            if (m0_readdatavalid && m1_readdatavalid)
                flag("beat_to_both", 64'(br_readdata));
        end
    end

    // Reference model: round-robin with hold-until-accepted and a bounded count of reads.
    task automatic model_step();
        bit r0, r1, creq, crd, ret, blocked;
        int cand, id;
        r0 = m0_read || m0_write;
        r1 = m1_read || m1_write;
        if (m_locked)          cand = m_owner;
        else if (r0 && r1)     cand = 1 - m_last;
        else                   cand = r1 ? 1 : 0;
        creq = (cand == 1) ? r1 : r0;
        crd  = (cand == 1) ? m1_read : m0_read;
        ret  = br_readdatavalid;
        blocked = crd && (m_pend.size() == MAX_PEND) && !ret;
        if (ret && m_pend.size() > 0) begin
            id = m_pend.pop_front();
            if (id == 0) exp_rd0.push_back(br_readdata);
            else         exp_rd1.push_back(br_readdata);
        end
        if (creq && !blocked) begin
            if (!br_waitrequest) begin
                if (cand == 0) push_cmd(0, m0_address, !crd, m0_writedata, m0_byteenable);
                else           push_cmd(1, m1_address, !crd, m1_writedata, m1_byteenable);
                if (crd) m_pend.push_back(cand);
                m_last   = cand;
                m_locked = 0;
            end else begin
                m_locked = 1;
                m_owner  = cand;
            end
        end
    endtask

    always begin
        @(posedge clk_clk);
        #2;
        if (model_on && !reset_reset) model_step();
    end

    task automatic run_master(input int id, input int n);
        int gap, waited;
        bit rd, done;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [3:0] be;
        cyc();
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) cyc();
            rd = 1'($urandom_range(0, 1));
            a  = ADDR_W'($urandom);
            d  = $urandom;
            be = 4'($urandom_range(1, 15));
            if (id == 0) begin
                m0_read = rd; m0_write = !rd; m0_address = a; m0_writedata = d;
                m0_byteenable = be;
            end else begin
                m1_read = rd; m1_write = !rd; m1_address = a; m1_writedata = d;
                m1_byteenable = be;
            end
            waited = 0;
            done   = 0;
            while (!done) begin
                smp();
                if (((id == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) begin
                    done = 1;
                end else if (++waited > 200) begin
                    flag("master_timeout", 64'(id));
                    done = 1;
                end
            end
            cyc();
            if (id == 0) begin m0_read = 0; m0_write = 0; end
            else         begin m1_read = 0; m1_write = 0; end
        end
    endtask

    // Bridge slave: random stalls, in-order returns after 1..4 cycles.
    task automatic run_bridge();
        int due_q[$];
        int cyc_n, last_due, d;
        cyc_n    = 0;
        last_due = 0;
        while (!(masters_done && due_q.size() == 0)) begin
            cyc();
            cyc_n++;
            br_waitrequest   = ($urandom_range(0, 2) == 0);
            br_readdatavalid = 0;
            if (due_q.size() > 0 && due_q[0] <= cyc_n && $urandom_range(0, 3) != 0) begin
                void'(due_q.pop_front());
                br_readdatavalid = 1;
                br_readdata      = $urandom;
            end
            smp();
            if (br_read && !br_waitrequest) begin
                d = cyc_n + int'($urandom_range(1, 4));
                if (d <= last_due) d = last_due + 1;
                due_q.push_back(d);
                last_due = d;
            end
            if (cyc_n > 20000) begin
                flag("bridge_timeout", 64'(due_q.size()));
                break;
            end
        end
        cyc();
        br_waitrequest   = 0;
        br_readdatavalid = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        reset_reset = 1;
        m0_read  = 1;
        m1_write = 1;
        #12;
        check("rst_br_read", 64'(br_read), 0);
        check("rst_br_write", 64'(br_write), 0);
        check("rst_m0_wait", 64'(m0_waitrequest), 1);
        check("rst_m1_wait", 64'(m1_waitrequest), 1);
        check("rst_m0_rdv", 64'(m0_readdatavalid), 0);
        do_reset();

        // Single master read, data two cycles later.
        cyc();
        push_cmd(0, 28'h0000010, 0, '0, 4'hF);
        m0_read = 1; m0_address = 28'h0000010;
        smp();
        check("t1_br_read", 64'(br_read), 1);
        cyc();
        m0_read = 0;
        cyc();
        exp_rd0.push_back(32'hDEADBEEF);
        br_readdatavalid = 1; br_readdata = 32'hDEADBEEF;
        smp();
        check("t1_m0_rdv", 64'(m0_readdatavalid), 1);
        check("t1_m1_rdv", 64'(m1_readdatavalid), 0);
        cyc();
        br_readdatavalid = 0;

        // Contention: both write every cycle, grants alternate starting with M0.
        do_reset();
        cyc();
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push_cmd(0, 28'h100, 1, 32'h11111111, 4'hF);
            else            push_cmd(1, 28'h200, 1, 32'h22222222, 4'h3);
        end
        m0_write = 1; m0_address = 28'h100; m0_writedata = 32'h11111111;
        m1_write = 1; m1_address = 28'h200; m1_writedata = 32'h22222222; m1_byteenable = 4'h3;
        for (int k = 0; k < 4; k++) begin
            smp();
            check("t2_m0_wait", 64'(m0_waitrequest), 64'(k % 2));
            cyc();
        end
        m0_write = 0; m1_write = 0; m1_byteenable = 4'hF;

        // Hold: M1 stalled three cycles, M0 waits, then gets the next slot.
        cyc();
        push_cmd(1, 28'h40, 1, 32'h0BADF00D, 4'hF);
        push_cmd(0, 28'h80, 0, '0, 4'hF);
        m1_write = 1; m1_address = 28'h40; m1_writedata = 32'h0BADF00D; br_waitrequest = 1;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin m0_read = 1; m0_address = 28'h80; end
            if (k == 3) br_waitrequest = 0;
            smp();
            check("t3_hold_addr", 64'(br_address), 64'h40);
            check("t3_m0_wait", 64'(m0_waitrequest), 1);
            cyc();
        end
        m1_write = 0;
        smp();
        check("t3_m0_granted", 64'(m0_waitrequest), 0);
        cyc();
        m0_read = 0;
        cyc();
        exp_rd0.push_back(32'h55AA55AA);
        br_readdatavalid = 1; br_readdata = 32'h55AA55AA;
        cyc();
        br_readdatavalid = 0;

        // Pipelined reads alternate M0/M1 and fill the FIFO.
        do_reset();
        cyc();
        for (int k = 0; k < 4; k++) push_cmd(k % 2, (k % 2) ? 28'h2000 : 28'h1000, 0, '0, 4'hF);
        m0_read = 1; m0_address = 28'h1000;
        m1_read = 1; m1_address = 28'h2000;
        for (int k = 0; k < 4; k++) begin
            smp();
            check("t4_m0_wait", 64'(m0_waitrequest), 64'(k % 2));
            cyc();
        end
        m0_read = 0; m1_read = 0;

        // FIFO full: writes still pass, reads wait for the first return beat.
        push_cmd(1, 28'h4000, 1, 32'hCAFEF00D, 4'hF);
        m1_write = 1; m1_address = 28'h4000; m1_writedata = 32'hCAFEF00D;
        smp();
        check("t5_write_when_full", 64'(br_write), 1);
        check("t5_m1_wait", 64'(m1_waitrequest), 0);
        cyc();
        m1_write = 0;
        m0_read = 1; m0_address = 28'h3000;
        for (int k = 0; k < 2; k++) begin
            smp();
            check("t5_read_blocked", 64'(br_read), 0);
            check("t5_m0_wait_blocked", 64'(m0_waitrequest), 1);
            cyc();
        end
        push_cmd(0, 28'h3000, 0, '0, 4'hF);
        exp_rd0.push_back(32'h1);
        br_readdatavalid = 1; br_readdata = 32'h1;
        smp();
        check("t5_read_on_pop", 64'(br_read), 1);
        check("t5_m0_wait_pop", 64'(m0_waitrequest), 0);
        cyc();
        m0_read = 0;
        for (int k = 2; k <= 5; k++) begin
            if (k % 2 == 0) exp_rd1.push_back(32'(k));
            else            exp_rd0.push_back(32'(k));
            br_readdata = 32'(k);
            cyc();
        end
        br_readdatavalid = 0;

        // Reset while in HOLD with two reads outstanding.
        push_cmd(0, 28'h500, 0, '0, 4'hF);
        push_cmd(1, 28'h600, 0, '0, 4'hF);
        m0_read = 1; m0_address = 28'h500;
        cyc();
        m0_read = 0;
        m1_read = 1; m1_address = 28'h600;
        cyc();
        m1_read = 0;
        m0_write = 1; m0_address = 28'h700; br_waitrequest = 1;
        cyc();
        smp();
        check("t6_hold_write", 64'(br_write), 1);
        #2;
        reset_reset = 1;
        #1;
        check("t6_async_br_write", 64'(br_write), 0);
        check("t6_async_br_read", 64'(br_read), 0);
        check("t6_async_m0_wait", 64'(m0_waitrequest), 1);
        cyc();
        clear_inputs();
        cyc();
        reset_reset = 0;
        cyc();
        push_cmd(0, 28'h800, 1, 32'hA0A0A0A0, 4'hF);
        push_cmd(1, 28'h900, 1, 32'hB0B0B0B0, 4'hF);
        m0_write = 1; m0_address = 28'h800; m0_writedata = 32'hA0A0A0A0;
        m1_write = 1; m1_address = 28'h900; m1_writedata = 32'hB0B0B0B0;
        smp();
        check("t6_first_tie_m0", 64'(m0_waitrequest), 0);
        cyc();
        m0_write = 0;
        cyc();
        m1_write = 0;
        for (int k = 0; k < MAX_PEND; k++) push_cmd(0, 28'hA00, 0, '0, 4'hF);
        m0_read = 1; m0_address = 28'hA00;
        for (int k = 0; k < MAX_PEND; k++) begin
            smp();
            check("t6_fifo_cleared", 64'(m0_waitrequest), 0);
            cyc();
        end
        m0_read = 0;
        br_readdatavalid = 1;
        for (int k = 0; k < MAX_PEND; k++) begin
            exp_rd0.push_back(32'h10 + 32'(k));
            br_readdata = 32'h10 + 32'(k);
            cyc();
        end
        br_readdatavalid = 0;

        // Randomized traffic against the model.
        do_reset();
        m_last   = 1;
        m_locked = 0;
        m_pend.delete();
        model_on = 1;
        fork
            begin
                fork
                    run_master(0, N_RAND);
                    run_master(1, N_RAND);
                join
                masters_done = 1;
            end
            run_bridge();
        join
        repeat (3) cyc();
        model_on = 0;

        check("left_cmds", 64'(exp_cmd.size()), 0);
        check("left_rd0", 64'(exp_rd0.size()), 0);
        check("left_rd1", 64'(exp_rd1.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
